// File: rtl/pconv_unit_param_if.sv
// Bus bundle for pconv_unit_param: the input beat channel and the activation output channel.
// Both channels use valid/ready: a transfer happens on a rising clk edge where vld && rdy;
// the source holds its data stable while vld is high and rdy is low.
interface pconv_unit_param_if #(
  parameter int N       = 16,
  parameter int CH      = 6,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5
) ();
  logic                in_vld;
  logic                in_rdy;
  logic [CH*N-1:0]     input_din;
  logic [CH*N-1:0]     weight_din;
  logic [ACC_W-1:0]    bias_din;
  logic [SHIFT_W-1:0]  shift_din;
  logic [N-1:0]        out_dout;
  logic                out_vld;
  logic                out_rdy;

  modport master (
    output in_vld, input_din, weight_din, bias_din, shift_din, out_rdy,
    input  in_rdy, out_dout, out_vld
  );

  modport slave (
    input  in_vld, input_din, weight_din, bias_din, shift_din, out_rdy,
    output in_rdy, out_dout, out_vld
  );
endinterface

// File: rtl/pconv_unit_param.sv
// Parametrised partial-convolution unit: CH products per beat, BEATS beats per output,
// then bias, arithmetic shift, ReLU and clamp to MAX. Define PCONV_ROUND_EN for round-half-up.
module pconv_unit_param #(
  parameter int N       = 16,
  parameter int CH      = 6,
  parameter int BEATS   = 1,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5,
  parameter int MAX     = 127
) (
  input  logic               clk,
  input  logic               rst,
  pconv_unit_param_if.slave  bus
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = 2 * N;
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX);

  // One enable freezes the whole pipeline while the output is held, so nothing is dropped.
  logic en;
  logic accept;
  logic last_beat;
  logic [CNT_W-1:0] beat_cnt;
  logic out_vld_r;
  logic [N-1:0] out_dout_r;

  assign en          = !out_vld_r || bus.out_rdy;
  assign accept      = bus.in_vld && en;
  assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
  assign bus.in_rdy  = en;
  assign bus.out_vld = out_vld_r;
  assign bus.out_dout = out_dout_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // S1: per-channel signed products
  logic signed [PW-1:0] prod [CH];
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      prod[i] = $signed(bus.input_din[i*N +: N]) * $signed(bus.weight_din[i*N +: N]);
    end
  end

  logic signed [PW-1:0]    s1_prod [CH];
  logic                    s1_vld;
  logic                    s1_last;
  logic signed [ACC_W-1:0] s1_bias;
  logic [SHIFT_W-1:0]      s1_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) s1_prod[i] <= '0;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_bias  <= '0;
      s1_shift <= '0;
    end else if (en) begin
      for (int i = 0; i < CH; i++) s1_prod[i] <= prod[i];
      s1_vld  <= accept;
      s1_last <= accept && last_beat;
      if (accept && last_beat) begin
        s1_bias  <= $signed(bus.bias_din);
        s1_shift <= bus.shift_din;
      end
    end
  end

  // S2: channel sum, sign-extended to the accumulator width
  logic signed [ACC_W-1:0] s1_sum;
  always_comb begin
    s1_sum = '0;
    for (int i = 0; i < CH; i++) begin
      s1_sum = s1_sum + ACC_W'(s1_prod[i]);
    end
  end

  logic signed [ACC_W-1:0] s2_sum;
  logic                    s2_vld;
  logic                    s2_last;
  logic signed [ACC_W-1:0] s2_bias;
  logic [SHIFT_W-1:0]      s2_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sum   <= '0;
      s2_vld   <= 1'b0;
      s2_last  <= 1'b0;
      s2_bias  <= '0;
      s2_shift <= '0;
    end else if (en) begin
      s2_sum   <= s1_sum;
      s2_vld   <= s1_vld;
      s2_last  <= s1_last;
      s2_bias  <= s1_bias;
      s2_shift <= s1_shift;
    end
  end

  // S3: accumulate; the last beat folds in the bias and restarts the accumulator
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] result;
  logic                    res_vld;
  logic [SHIFT_W-1:0]      s3_shift;

  assign acc_next = acc + s2_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      result   <= '0;
      res_vld  <= 1'b0;
      s3_shift <= '0;
    end else if (en) begin
      res_vld <= s2_vld && s2_last;
      if (s2_vld) begin
        if (s2_last) begin
          result   <= acc_next + s2_bias;
          s3_shift <= s2_shift;
          acc      <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

  // S4: optional rounding, arithmetic shift, ReLU and clamp
  logic signed [ACC_W-1:0] pre;
  logic signed [ACC_W-1:0] shifted;
  logic [N-1:0]            act;

`ifdef PCONV_ROUND_EN
  logic [ACC_W:0]        rnd;
  logic signed [ACC_W:0] rsum;
  always_comb begin
    rnd = '0;
    if (s3_shift != '0) rnd = (ACC_W+1)'(1) << (s3_shift - 1'b1);
    rsum = $signed({result[ACC_W-1], result}) + $signed(rnd);
    // Only a positive addend is used, so overflow can only go past the top.
    if (rsum[ACC_W] != rsum[ACC_W-1]) pre = {1'b0, {(ACC_W-1){1'b1}}};
    else                             pre = rsum[ACC_W-1:0];
  end
`else
  assign pre = result;
`endif

  always_comb begin
    shifted = pre >>> s3_shift;
    if (shifted[ACC_W-1])    act = '0;
    else if (shifted > MAX_S) act = N'(MAX);
    else                     act = shifted[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_dout_r <= '0;
    end else if (en) begin
      out_vld_r <= res_vld;
      if (res_vld) out_dout_r <= act;
    end
  end
endmodule

// File: tb/tb_pconv_unit_param.sv
// Directed bench for pconv_unit_param: one BEATS=1 and one BEATS=3 instance, expected
// activations queued at issue time and popped by per-instance output monitors.
module tb_pconv_unit_param;
  localparam int N = 16, CH = 6, ACC_W = 32, SHIFT_W = 5, MAX = 127;
  localparam int CW = CH * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [N-1:0] exp_q1[$];
  logic [N-1:0] exp_q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pconv_unit_param_if #(.N(N), .CH(CH), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) b1_if ();
  pconv_unit_param_if #(.N(N), .CH(CH), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) b3_if ();

  pconv_unit_param #(.N(N), .CH(CH), .BEATS(1), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W), .MAX(MAX))
    u_b1 (.clk(clk), .rst(rst), .bus(b1_if));
  pconv_unit_param #(.N(N), .CH(CH), .BEATS(3), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W), .MAX(MAX))
    u_b3 (.clk(clk), .rst(rst), .bus(b3_if));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [CW-1:0] fill(input int v);
    logic [CW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*N +: N] = v[N-1:0];
    return r;
  endfunction

  function automatic logic [CW-1:0] one(input int v);
    logic [CW-1:0] r;
    r = '0;
    r[N-1:0] = v[N-1:0];
    return r;
  endfunction

  function automatic logic [CW-1:0] pack6(input int a, b, c, d, e, f);
    logic [CW-1:0] r;
    r = {f[N-1:0], e[N-1:0], d[N-1:0], c[N-1:0], b[N-1:0], a[N-1:0]};
    return r;
  endfunction

  // Driver: present a beat at negedge, hold until accepted on a rising edge.
  task automatic beat(input int d, input logic [CW-1:0] din, input logic [CW-1:0] win,
                      input logic [31:0] bias, input logic [4:0] sh);
    int g;
    g = 0;
    @(negedge clk);
    if (d == 0) begin
      b1_if.in_vld = 1'b1; b1_if.input_din = din; b1_if.weight_din = win;
      b1_if.bias_din = bias; b1_if.shift_din = sh;
    end else begin
      b3_if.in_vld = 1'b1; b3_if.input_din = din; b3_if.weight_din = win;
      b3_if.bias_din = bias; b3_if.shift_din = sh;
    end
    while (((d == 0) ? !b1_if.in_rdy : !b3_if.in_rdy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("in_rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int d);
    @(negedge clk);
    if (d == 0) b1_if.in_vld = 1'b0;
    else        b3_if.in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q1.size() != 0 || exp_q3.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitors: a transfer is seen at negedge when vld and rdy are both high.
  always @(negedge clk) begin
    if (!rst && b1_if.out_vld && b1_if.out_rdy) begin
      if (exp_q1.size() == 0) chk("b1_unexpected_out", 32'(b1_if.out_dout), 32'hFFFF_FFFF);
      else chk("b1_out", 32'(b1_if.out_dout), 32'(exp_q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && b3_if.out_vld && b3_if.out_rdy) begin
      if (exp_q3.size() == 0) chk("b3_unexpected_out", 32'(b3_if.out_dout), 32'hFFFF_FFFF);
      else chk("b3_out", 32'(b3_if.out_dout), 32'(exp_q3.pop_front()));
    end
  end

  initial begin
    int k;
    int g;
    b1_if.in_vld = 1'b0; b1_if.input_din = '0; b1_if.weight_din = '0;
    b1_if.bias_din = '0; b1_if.shift_din = '0; b1_if.out_rdy = 1'b1;
    b3_if.in_vld = 1'b0; b3_if.input_din = '0; b3_if.weight_din = '0;
    b3_if.bias_din = '0; b3_if.shift_din = '0; b3_if.out_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_b1_out_vld", 32'(b1_if.out_vld), 0);
    chk("rst_b1_out_dout", 32'(b1_if.out_dout), 0);
    chk("rst_b1_in_rdy", 32'(b1_if.in_rdy), 1);
    chk("rst_b3_out_vld", 32'(b3_if.out_vld), 0);
    chk("rst_b3_in_rdy", 32'(b3_if.in_rdy), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 6*(10*2)+8 = 128 -> clamp 127, with latency measured from the accept cycle
    exp_q1.push_back(16'd127);
    beat(0, fill(10), fill(2), 32'd8, 5'd0);
    k = cyc;
    drop(0);
    g = 0;
    while (!b1_if.out_vld && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("b1_latency", 32'(cyc - (k - 1)), 4);

    exp_q1.push_back(16'd64);                      // 128 >>> 1
    beat(0, fill(10), fill(2), 32'd8, 5'd1);
    exp_q1.push_back(16'd0);                       // -120+8 = -112 -> ReLU
    beat(0, fill(10), fill(-2), 32'd8, 5'd0);
    exp_q1.push_back(16'd37);                      // 20-12+15-7+0+4 = 20, +17
    beat(0, pack6(10, -3, 5, 7, 0, 1), pack6(2, 4, 3, -1, 9, 4), 32'd17, 5'd0);
    exp_q1.push_back(16'd127);                     // exactly MAX passes through
    beat(0, one(127), one(1), 32'd0, 5'd0);
    exp_q1.push_back(16'd64);                      // 2^30 >>> 24, rounding bit below half
    beat(0, fill(0), fill(0), 32'h4000_0000, 5'd24);
`ifdef PCONV_ROUND_EN
    exp_q1.push_back(16'd3);
    beat(0, one(5), one(1), 32'd0, 5'd1);
    exp_q1.push_back(16'd1);
    beat(0, one(3), one(1), 32'd0, 5'd2);
`else
    exp_q1.push_back(16'd2);
    beat(0, one(5), one(1), 32'd0, 5'd1);
    exp_q1.push_back(16'd0);
    beat(0, one(3), one(1), 32'd0, 5'd2);
`endif
    drop(0);
    wait_drain();

    // Backpressure: hold out_rdy low while six beats are offered
    fork
      begin
        for (int v = 11; v <= 16; v++) begin
          exp_q1.push_back(16'(v));
          beat(0, one(v), one(1), 32'd0, 5'd0);
        end
        drop(0);
      end
      begin
        @(posedge clk);
        #1 b1_if.out_rdy = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("bp_out_vld_held", 32'(b1_if.out_vld), 1);
        chk("bp_in_rdy_low", 32'(b1_if.in_rdy), 0);
        @(posedge clk);
        #1 b1_if.out_rdy = 1'b1;
      end
    join
    wait_drain();

    // BEATS=3: bias on non-last beats must be ignored
    beat(1, one(5), one(1), 32'd1000, 5'd3);
    beat(1, one(7), one(1), 32'd1000, 5'd3);
    exp_q3.push_back(16'd21);
    beat(1, one(9), one(1), 32'd0, 5'd0);
    beat(1, one(1), one(1), 32'd0, 5'd0);
    beat(1, one(1), one(1), 32'd0, 5'd0);
    exp_q3.push_back(16'd3);
    beat(1, one(1), one(1), 32'd0, 5'd0);
    drop(1);
    wait_drain();

    // Reset with a held output and a partial group in flight; neither may survive
    @(posedge clk);
    #1 b3_if.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) beat(1, one(1), one(1), 32'd0, 5'd0);
    beat(1, one(50), one(1), 32'd0, 5'd0);
    beat(1, one(50), one(1), 32'd0, 5'd0);
    drop(1);
    repeat (6) @(negedge clk);
    chk("b3_held_before_rst", 32'(b3_if.out_vld), 1);
    rst = 1'b1;
    #1;
    chk("b3_out_vld_async_rst", 32'(b3_if.out_vld), 0);
    chk("b3_in_rdy_in_rst", 32'(b3_if.in_rdy), 1);
    @(negedge clk);
    rst = 1'b0;
    b3_if.out_rdy = 1'b1;
    beat(1, one(2), one(1), 32'd0, 5'd0);
    beat(1, one(2), one(1), 32'd0, 5'd0);
    exp_q3.push_back(16'd6);
    beat(1, one(2), one(1), 32'd0, 5'd0);
    drop(1);
    wait_drain();

    chk("b1_queue_empty", 32'(exp_q1.size()), 0);
    chk("b3_queue_empty", 32'(exp_q3.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pconv_unit_param.md
Name: pconv_unit_param

Overview:
Parametrised successor to the fixed 6-channel partial-convolution unit. Computes CH parallel signed products per beat, sums them in a registered adder stage, and accumulates BEATS beats (kernel taps) per output. It then adds bias, applies an arithmetic right shift, ReLU and upper clamp to MAX, and emits one N-bit activation through a valid/ready output. It sits between the feature/weight line buffers and the activation store of each conv layer.

Parameters:
N, 16, input/weight/output data width (signed two's complement in, unsigned out)
CH, 6, parallel channels (products per beat), 1..32
BEATS, 1, beats accumulated per output, 1..256
ACC_W, 32, accumulator/bias width, must be >= 2N+clog2(CH*BEATS)
SHIFT_W, 5, width of shift amount
MAX, 127, saturation ceiling of output (must be < 2^N)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_vld  in  1  input beat valid
in_rdy  out  1  unit can accept a beat this cycle
input_din  in  CH*N  CH signed activations, channel i at [(i+1)*N-1:i*N]
weight_din  in  CH*N  CH signed weights, same packing
bias_din  in  ACC_W  signed bias, sampled with the last beat of an output
shift_din  in  SHIFT_W  right-shift amount, sampled with the last beat
out_dout  out  N  activation result
out_vld  out  1  out_dout valid
out_rdy  in  1  downstream accepts out_dout

Behaviour:
- Reset (async, rst=1): beat counter=0, all stage valid flags=0, accumulator=0, out_vld=0, out_dout=0. Any partially accumulated output is discarded. in_rdy=1 after reset.
- Global advance enable en = !out_vld || out_rdy. in_rdy = en. Beat accepted when in_vld && in_rdy. When en=0 every pipeline register holds its value; there are no bubbles and no data loss.
- S1 (register): CH signed N x N products, 2N bits each, plus valid and last flag. bias/shift are captured into S1 when last.
- S2 (register): sign-extended sum of all CH products to ACC_W bits, carrying valid/last/bias/shift forward.
- S3 (register): on valid, acc_next = acc + S2 sum. If last, result = acc_next + bias (ACC_W, wraps modulo 2^ACC_W), result-valid set, acc cleared to 0. Otherwise acc = acc_next and no result is produced.
- S4/output register: t = result >>> shift (arithmetic). Then out_dout = 0 if t < 0, MAX if t > MAX, else t[N-1:0]. out_vld is set when a result enters the register. It is cleared on out_rdy handshake unless a new result enters in the same cycle.
- Beat counter: increments on each accepted beat. A beat is last when counter == BEATS-1, after which the counter returns to 0. When BEATS=1, every beat is last.
- Latency: the last beat accepted at cycle t produces out_vld=1 at t+4 with no stalls. Throughput is one beat per cycle, so one output per BEATS cycles.
- Back-to-back: a new result may load the output register in the same cycle out_rdy consumes the previous one.
- Stall with in_vld=0 holds all state. The accumulator is never cleared by idle cycles.
- Shift >= ACC_W yields 0 for non-negative results and -1 (ReLU gives 0) for negative results.

Optional Feature:
PCONV_ROUND_EN: when defined, S4 adds 2^(shift-1) to result before the arithmetic shift when shift > 0, giving round-half-up. The add saturates instead of wrapping on overflow. When undefined, the shift truncates toward -inf with no add. Latency is identical in both builds.

Test Plan:
- CH=6, BEATS=1, all inputs 10, weights 2, bias 8, shift 0 -> sum 128, out_dout=127 (clamp), out_vld 4 cycles after in_vld; same with shift 1 -> 64.
- Weights -2, inputs 10, bias 8, shift 0 -> -112, out_dout=0 (ReLU); mixed-sign inputs giving 37 -> out_dout=37.
- BEATS=3, per-beat sums 5, 7, 9, bias 0, shift 0 -> single output 21 after third beat; next group starts from acc=0 (verify with sums 1,1,1 -> 3).
- Backpressure: out_rdy=0 for 5 cycles while feeding beats -> in_rdy drops once out_vld=1, no result lost; release gives in-order outputs with one output per handshake.
- Reset asserted mid-group (after 2 of 3 beats) -> out_vld=0 immediately; subsequent full group of sums 2,2,2 -> out_dout=6 (no stale partial).
- Result 5, shift 1 -> out_dout=2 without PCONV_ROUND_EN, 3 with it; result 3, shift 2 -> 0 without, 1 with.
